// File: rtl/tdm_pkg.sv
// Shared types and constants for the 8-lane TDM demultiplexer.
// Lane count, select width, FSM encodings and the flat-bus lane-slice helper.
package tdm_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_HUNT = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_ADDR = 2'd2;

    // Low bit index of lane k inside a flat LANES*width bus.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/demux_decode3to8.sv
// 3-to-8 one-hot decoder shared by the shadow-write and addressed-write paths.
module demux_decode3to8
    import tdm_pkg::*;
(
    input  logic [SEL_W-1:0] idx,
    output logic [LANES-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/tdm_demux8.sv
// 1-to-8 TDM demultiplexer: rebuilds eight registered channels from a framed
// serial lane, or writes single lanes directly in addressed mode.
module tdm_demux8 #(
    parameter int DATA_W = 1,
    parameter int LANES  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic [DATA_W-1:0]           din,
    input  logic                        din_valid,
    input  logic                        sof,
    input  logic [tdm_pkg::SEL_W-1:0]   sel,
    output logic [LANES*DATA_W-1:0]     dout,
    output logic                        frame_valid,
    output logic [LANES-1:0]            lane_strobe,
    output logic [tdm_pkg::SEL_W-1:0]   slot,
    output logic                        sync_err
);
    import tdm_pkg::*;

    state_t                          state;
    state_t                          eff_state;
    logic [SEL_W-1:0]                slot_q;
    logic [SEL_W-1:0]                dec_idx;
    logic [LANES-1:0]                dec;
    logic [LANES-1:0][DATA_W-1:0]    dout_q;
    logic [LANES-2:0][DATA_W-1:0]    shadow;

    // Mode acts on the same edge it changes, so a beat on the switching
    // edge is handled under the new mode.
    always_comb begin
        eff_state = state;
        if (mode)
            eff_state = ST_ADDR;
        else if (state == ST_ADDR)
            eff_state = ST_HUNT;
    end

    assign dec_idx = (eff_state == ST_ADDR) ? sel : slot_q;

    demux_decode3to8 u_dec (
        .idx    (dec_idx),
        .onehot (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_HUNT;
            slot_q      <= '0;
            shadow      <= '0;
            dout_q      <= '0;
            frame_valid <= 1'b0;
            lane_strobe <= '0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            lane_strobe <= '0;
            sync_err    <= 1'b0;
            state       <= eff_state;

            case (eff_state)
                ST_ADDR: begin
                    slot_q <= '0;
                    if (state != ST_ADDR)
                        shadow <= '0;
                    if (din_valid) begin
                        for (int k = 0; k < LANES; k++)
                            if (dec[k])
                                dout_q[k] <= din;
                        lane_strobe <= dec;
                    end
                end

                ST_HUNT: begin
                    if (din_valid && sof) begin
                        shadow    <= '0;
                        shadow[0] <= din;
                        slot_q    <= SEL_W'(1);
                        state     <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (din_valid) begin
                        if (sof) begin
                            // A misplaced sof restarts the frame rather than dropping it.
                            sync_err  <= (slot_q != '0);
                            shadow    <= '0;
                            shadow[0] <= din;
                            slot_q    <= SEL_W'(1);
                        end else if (slot_q == '0) begin
                            sync_err <= 1'b1;
                            state    <= ST_HUNT;
                        end else if (slot_q == SEL_W'(LANES - 1)) begin
                            dout_q      <= {din, shadow};
                            frame_valid <= 1'b1;
                            slot_q      <= '0;
                        end else begin
                            for (int k = 0; k < LANES - 1; k++)
                                if (dec[k])
                                    shadow[k] <= din;
                            slot_q <= slot_q + SEL_W'(1);
                        end
                    end
                end

                default: state <= ST_HUNT;
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign dout[lane_lo(k, DATA_W) +: DATA_W] = dout_q[k];
    end

    assign slot = slot_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Table-driven bench for tdm_demux8 with a scoreboard of expected outputs.
module tb_tdm_demux8;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [0:0] din;
    logic       din_valid;
    logic       sof;
    logic [2:0] sel;
    logic [7:0] dout;
    logic       frame_valid;
    logic [7:0] lane_strobe;
    logic [2:0] slot;
    logic       sync_err;

    typedef struct {
        bit       mode;
        bit       dv;
        bit       sof;
        bit       din;
        bit [2:0] sel;
        bit [7:0] e_dout;
        bit       e_fv;
        bit [7:0] e_ls;
        bit [2:0] e_slot;
        bit       e_se;
    } vec_t;

    typedef struct {
        bit [7:0] dout;
        bit       fv;
        bit [7:0] ls;
        bit [2:0] slot;
        bit       se;
        int       id;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   vid   = 0;

    tdm_demux8 #(.DATA_W(1), .LANES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .sel         (sel),
        .dout        (dout),
        .frame_valid (frame_valid),
        .lane_strobe (lane_strobe),
        .slot        (slot),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input bit m, input bit dv, input bit s, input bit d, input bit [2:0] sl,
                       input bit [7:0] ed, input bit efv, input bit [7:0] els,
                       input bit [2:0] eslot, input bit ese);
        vec_t v;
        v.mode = m; v.dv = dv; v.sof = s; v.din = d; v.sel = sl;
        v.e_dout = ed; v.e_fv = efv; v.e_ls = els; v.e_slot = eslot; v.e_se = ese;
        tbl.push_back(v);
    endtask

    task automatic push_exp(input bit [7:0] ed, input bit efv, input bit [7:0] els,
                            input bit [2:0] eslot, input bit ese);
        exp_t e;
        e.dout = ed; e.fv = efv; e.ls = els; e.slot = eslot; e.se = ese; e.id = vid;
        vid++;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: no expected entry queued for vector %0d", n_vec);
            return;
        end
        e = sb.pop_front();
        if ({dout, frame_valid, lane_strobe, slot, sync_err} !==
            {e.dout, e.fv, e.ls, e.slot, e.se}) begin
            n_err++;
            $display("FAIL vec%0d: got dout=%h fv=%b ls=%h slot=%0d se=%b, expected dout=%h fv=%b ls=%h slot=%0d se=%b",
                     e.id, dout, frame_valid, lane_strobe, slot, sync_err,
                     e.dout, e.fv, e.ls, e.slot, e.se);
        end
    endtask

    task automatic apply(input vec_t v);
        mode      = v.mode;
        din_valid = v.dv;
        sof       = v.sof;
        din       = v.din;
        sel       = v.sel;
        push_exp(v.e_dout, v.e_fv, v.e_ls, v.e_slot, v.e_se);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; din = '0; din_valid = 1'b0; sof = 1'b0; sel = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        push_exp(8'h00, 0, 8'h00, 3'd0, 0);
        check_out();
        rst = 1'b0;

        // Beats without sof are ignored while hunting.
        for (int i = 0; i < 3; i++) add(0,1,0,1,0, 8'h00,0,8'h00,3'd0,0);
        // Frame 1,0,0,0,0,0,0,0 -> 01.
        add(0,1,1,1,0, 8'h00,0,8'h00,3'd1,0);
        for (int s = 1; s < 7; s++) add(0,1,0,0,0, 8'h00,0,8'h00,3'(s+1),0);
        add(0,1,0,0,0, 8'h01,1,8'h00,3'd0,0);
        add(0,0,0,0,0, 8'h01,0,8'h00,3'd0,0);
        // Frame 0,..,0,1 with stalls -> 80.
        add(0,1,1,0,0, 8'h01,0,8'h00,3'd1,0);
        add(0,0,0,0,0, 8'h01,0,8'h00,3'd1,0);
        for (int s = 1; s < 7; s++) begin
            add(0,1,0,0,0, 8'h01,0,8'h00,3'(s+1),0);
            add(0,0,0,0,0, 8'h01,0,8'h00,3'(s+1),0);
        end
        add(0,1,0,1,0, 8'h80,1,8'h00,3'd0,0);
        add(0,0,0,0,0, 8'h80,0,8'h00,3'd0,0);
        // Early sof at slot 5 restarts; new frame 0,1,0,1,0,1,0,1 -> AA.
        add(0,1,1,1,0, 8'h80,0,8'h00,3'd1,0);
        for (int s = 1; s < 5; s++) add(0,1,0,1,0, 8'h80,0,8'h00,3'(s+1),0);
        add(0,1,1,0,0, 8'h80,0,8'h00,3'd1,1);
        for (int s = 1; s < 7; s++) add(0,1,0,s[0],0, 8'h80,0,8'h00,3'(s+1),0);
        add(0,1,0,1,0, 8'hAA,1,8'h00,3'd0,0);
        // Missing sof: error then back to hunting.
        add(0,1,0,1,0, 8'hAA,0,8'h00,3'd0,1);
        add(0,1,0,1,0, 8'hAA,0,8'h00,3'd0,0);
        // Addressed mode, sof toggled to show it is ignored.
        add(1,1,0,1,3'd0, 8'hAB,0,8'h01,3'd0,0);
        add(1,1,1,1,3'd1, 8'hAB,0,8'h02,3'd0,0);
        add(1,1,0,1,3'd2, 8'hAF,0,8'h04,3'd0,0);
        add(1,1,1,1,3'd3, 8'hAF,0,8'h08,3'd0,0);
        add(1,1,0,1,3'd4, 8'hBF,0,8'h10,3'd0,0);
        add(1,1,1,1,3'd5, 8'hBF,0,8'h20,3'd0,0);
        add(1,1,0,1,3'd6, 8'hFF,0,8'h40,3'd0,0);
        add(1,1,1,1,3'd7, 8'hFF,0,8'h80,3'd0,0);
        add(1,1,0,0,3'd3, 8'hF7,0,8'h08,3'd0,0);
        add(1,0,0,1,3'd5, 8'hF7,0,8'h00,3'd0,0);
        // Back to TDM: hunting, dout kept; then start a frame (3 beats).
        add(0,1,0,1,0, 8'hF7,0,8'h00,3'd0,0);
        add(0,1,1,1,0, 8'hF7,0,8'h00,3'd1,0);
        add(0,1,0,0,0, 8'hF7,0,8'h00,3'd2,0);
        add(0,1,0,0,0, 8'hF7,0,8'h00,3'd3,0);
        run_table();

        // Asynchronous reset mid-frame: outputs clear before any clock edge.
        rst = 1'b1;
        din_valid = 1'b0;
        #2;
        push_exp(8'h00, 0, 8'h00, 3'd0, 0);
        check_out();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // After reset a frame needs sof again; 0->1 mid-frame drops it quietly.
        add(0,1,0,1,0, 8'h00,0,8'h00,3'd0,0);
        add(0,1,1,1,0, 8'h00,0,8'h00,3'd1,0);
        add(0,1,0,1,0, 8'h00,0,8'h00,3'd2,0);
        add(1,0,0,1,0, 8'h00,0,8'h00,3'd0,0);
        add(0,1,0,1,0, 8'h00,0,8'h00,3'd0,0);
        run_table();

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d expected entries left unchecked", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
